exp_gpio_ctrl: RTL and testbench

//   Parametrised expansion-header GPIO controller. Per-pin direction, output data, input sync (opt. debounce),

---
 rtl/exp_gpio_pkg.sv | 19 +
 rtl/gpio_in_cond.sv | 52 +++++
 rtl/exp_gpio_ctrl.sv | 111 +++++++++++
 tb/tb_exp_gpio_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp_gpio_pkg.sv
// Shared definitions for the expansion-header GPIO controller: register map, bus width,
// and edge-select encoding.
package exp_gpio_pkg;

    localparam int unsigned REG_W = 32;

    localparam logic [2:0] ADDR_DIR        = 3'd0;
    localparam logic [2:0] ADDR_OUT        = 3'd1;
    localparam logic [2:0] ADDR_IN         = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd4;
    localparam logic [2:0] ADDR_EDGE_SEL   = 3'd5;

    typedef enum logic {
        EdgeRise = 1'b0,
        EdgeFall = 1'b1
    } edge_sel_e;

endpackage

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioning: 2-FF synchroniser followed by the in_q register.
// With EXP_GPIO_DEBOUNCE_EN defined, in_q only follows a value held stable for DEBOUNCE_CYCLES.
module gpio_in_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic in_q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pin};
        end
    end

`ifdef EXP_GPIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter only runs while the synced value disagrees with in_q; any bounce back clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            in_q  <= 1'b0;
        end else if (sync_q[1] == in_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            in_q  <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= sync_q[1];
        end
    end
`endif

endmodule

// File: rtl/exp_gpio_ctrl.sv
// Expansion-header GPIO controller: register file, pad drive, edge-detect interrupts.
// Define EXP_GPIO_DEBOUNCE_EN to add per-pin input debouncing.
module exp_gpio_ctrl
    import exp_gpio_pkg::*;
#(
    parameter int unsigned NUM_PINS        = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reg_wr,
    input  logic                reg_rd,
    input  logic [2:0]          reg_addr,
    input  logic [REG_W-1:0]    reg_wdata,
    output logic [REG_W-1:0]    reg_rdata,
    output logic                reg_rvalid,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe,
    output logic                irq
);

    logic [NUM_PINS-1:0] dir_q, out_q, irq_en_q, irq_status_q, edge_sel_q;
    logic [NUM_PINS-1:0] irq_status_d;
    logic [NUM_PINS-1:0] in_q, in_prev_q, edge_evt;
    logic [NUM_PINS-1:0] wdata_pins, status_clr;
    logic [NUM_PINS-1:0] rd_pins;
    logic [REG_W-1:0]    rdata_d;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_in
        gpio_in_cond #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_in_cond (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (pin_in[i]),
            .in_q   (in_q[i])
        );
    end

    assign wdata_pins = reg_wdata[NUM_PINS-1:0];
    assign status_clr = (reg_wr && reg_addr == ADDR_IRQ_STATUS) ? wdata_pins : '0;

    // Output pins never raise events; in_prev keeps tracking so a DIR flip sees no stale edge.
    always_comb begin
        edge_evt = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (!dir_q[i]) begin
                if (edge_sel_e'(edge_sel_q[i]) == EdgeFall) begin
                    edge_evt[i] = in_prev_q[i] & ~in_q[i];
                end else begin
                    edge_evt[i] = ~in_prev_q[i] & in_q[i];
                end
            end
        end
    end

    // Set wins over a same-cycle write-1-to-clear.
    assign irq_status_d = (irq_status_q & ~status_clr) | edge_evt;

    always_comb begin
        rd_pins = '0;
        case (reg_addr)
            ADDR_DIR:        rd_pins = dir_q;
            ADDR_OUT:        rd_pins = out_q;
            ADDR_IN:         rd_pins = in_q;
            ADDR_IRQ_EN:     rd_pins = irq_en_q;
            ADDR_IRQ_STATUS: rd_pins = irq_status_q;
            ADDR_EDGE_SEL:   rd_pins = edge_sel_q;
            default:         rd_pins = '0;
        endcase
        rdata_d = '0;
        rdata_d[NUM_PINS-1:0] = rd_pins;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q        <= '0;
            out_q        <= '0;
            irq_en_q     <= '0;
            irq_status_q <= '0;
            edge_sel_q   <= '0;
            in_prev_q    <= '0;
            pin_out      <= '0;
            pin_oe       <= '0;
            irq          <= 1'b0;
            reg_rdata    <= '0;
            reg_rvalid   <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (reg_addr)
                    ADDR_DIR:      dir_q      <= wdata_pins;
                    ADDR_OUT:      out_q      <= wdata_pins;
                    ADDR_IRQ_EN:   irq_en_q   <= wdata_pins;
                    ADDR_EDGE_SEL: edge_sel_q <= wdata_pins;
                    default:       ;
                endcase
            end
            irq_status_q <= irq_status_d;
            in_prev_q    <= in_q;
            pin_out      <= out_q;
            pin_oe       <= dir_q;
            irq          <= |(irq_status_q & irq_en_q);
            reg_rvalid   <= reg_rd;
            if (reg_rd) begin
                reg_rdata <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_exp_gpio_ctrl.sv
// Directed self-checking bench for exp_gpio_ctrl (NUM_PINS=8, DEBOUNCE_CYCLES=8).
// Debounce vectors run only when EXP_GPIO_DEBOUNCE_EN is defined.
module tb_exp_gpio_ctrl;
    import exp_gpio_pkg::*;

    localparam int unsigned NUM_PINS = 8;
    localparam int unsigned DB       = 8;
`ifdef EXP_GPIO_DEBOUNCE_EN
    localparam int unsigned LAT = 2 + DB;
`else
    localparam int unsigned LAT = 3;
`endif

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                reg_wr = 1'b0;
    logic                reg_rd = 1'b0;
    logic [2:0]          reg_addr = '0;
    logic [31:0]         reg_wdata = '0;
    logic [31:0]         reg_rdata;
    logic                reg_rvalid;
    logic [NUM_PINS-1:0] pin_in = '0;
    logic [NUM_PINS-1:0] pin_out;
    logic [NUM_PINS-1:0] pin_oe;
    logic                irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rdat;
    logic [31:0] in_base;

    always #5 clk = ~clk;

    exp_gpio_ctrl #(
        .NUM_PINS       (NUM_PINS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_rvalid(reg_rvalid),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .irq       (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_addr = a;
        reg_rd   = 1'b1;
        tick();
        reg_rd   = 1'b0;
        check_eq("rvalid", {31'b0, reg_rvalid}, 32'h1);
        d = reg_rdata;
    endtask

    initial begin
        // Reset held while pads toggle
        for (int i = 0; i < 6; i++) begin
            pin_in = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        pin_in = '0;
        check_eq("rst_pin_oe", {24'b0, pin_oe}, 32'h0);
        check_eq("rst_pin_out", {24'b0, pin_out}, 32'h0);
        check_eq("rst_irq", {31'b0, irq}, 32'h0);
        check_eq("rst_rvalid", {31'b0, reg_rvalid}, 32'h0);
        check_eq("rst_rdata", reg_rdata, 32'h0);
        reset_n = 1'b1;
        repeat (LAT + 2) tick();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), rdat);
            check_eq($sformatf("rst_reg%0d", a), rdat, 32'h0);
        end
        tick();
        check_eq("rvalid_drop", {31'b0, reg_rvalid}, 32'h0);

        // Drive outputs, one-cycle lag to the pads
        wr(ADDR_DIR, 32'h0000_00FF);
        wr(ADDR_OUT, 32'h0000_00A5);
        check_eq("pin_oe", {24'b0, pin_oe}, 32'hFF);
        check_eq("pin_out_lag", {24'b0, pin_out}, 32'h00);
        tick();
        check_eq("pin_out", {24'b0, pin_out}, 32'hA5);
        rd(ADDR_OUT, rdat);
        check_eq("rd_out", rdat, 32'hA5);
        wr(ADDR_DIR, 32'hFFFF_FFFF);
        rd(ADDR_DIR, rdat);
        check_eq("dir_upper_bits", rdat, 32'hFF);
        wr(ADDR_DIR, 32'h0);
        wr(ADDR_OUT, 32'h0);

        // Rising edge on pin 0 with interrupt enabled
        wr(ADDR_IRQ_EN, 32'h1);
        pin_in[0] = 1'b1;
        repeat (LAT - 1) tick();
        rd(ADDR_IN, rdat);
        check_eq("in0_before", rdat, 32'h0);
        rd(ADDR_IN, rdat);
        check_eq("in0_after", rdat, 32'h1);
        check_eq("irq_not_yet", {31'b0, irq}, 32'h0);
        tick();
        check_eq("irq_set", {31'b0, irq}, 32'h1);
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("status_rise", rdat, 32'h1);
        wr(ADDR_IRQ_STATUS, 32'h1);
        check_eq("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        check_eq("irq_clr", {31'b0, irq}, 32'h0);
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("status_clr", rdat, 32'h0);

        // Set wins over same-cycle W1C on pin 3 (falling-edge select)
        wr(ADDR_EDGE_SEL, 32'h8);
        pin_in[3] = 1'b1;
        repeat (LAT + 3) tick();
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("fallsel_no_rise", rdat, 32'h0);
        pin_in[3] = 1'b0;
        repeat (LAT) tick();
        wr(ADDR_IRQ_STATUS, 32'h8);
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("set_wins", rdat, 32'h8);
        check_eq("irq_masked", {31'b0, irq}, 32'h0);
        wr(ADDR_IRQ_STATUS, 32'h8);
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("w1c_bit3", rdat, 32'h0);

        in_base = 32'h1;
`ifdef EXP_GPIO_DEBOUNCE_EN
        // Short glitch filtered, long hold accepted after 2 + DB edges
        pin_in[2] = 1'b1;
        repeat (5) tick();
        pin_in[2] = 1'b0;
        repeat (15) tick();
        rd(ADDR_IN, rdat);
        check_eq("db_glitch_in", rdat, 32'h1);
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("db_glitch_status", rdat, 32'h0);
        pin_in[2] = 1'b1;
        repeat (9) tick();
        rd(ADDR_IN, rdat);
        check_eq("db_hold_early", rdat, 32'h1);
        rd(ADDR_IN, rdat);
        check_eq("db_hold_in", rdat, 32'h5);
        tick();
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("db_hold_status", rdat, 32'h4);
        wr(ADDR_IRQ_STATUS, 32'hFF);
        in_base = 32'h5;
`endif

        // Output pin reads back but raises no status
        wr(ADDR_DIR, 32'h10);
        wr(ADDR_IRQ_EN, 32'h11);
        wr(ADDR_OUT, 32'h10);
        pin_in[4] = 1'b1;
        repeat (LAT + 3) tick();
        rd(ADDR_IN, rdat);
        check_eq("out_pin_in_hi", rdat, in_base | 32'h10);
        pin_in[4] = 1'b0;
        repeat (LAT + 3) tick();
        rd(ADDR_IN, rdat);
        check_eq("out_pin_in_lo", rdat, in_base);
        rd(ADDR_IRQ_STATUS, rdat);
        check_eq("out_pin_status", rdat, 32'h0);
        check_eq("out_pin_irq", {31'b0, irq}, 32'h0);
        rd(3'd6, rdat);
        check_eq("rsvd6", rdat, 32'h0);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, rdat);
        check_eq("rsvd7", rdat, 32'h0);
        wr(ADDR_IN, 32'hFFFF_FFFF);
        rd(ADDR_IN, rdat);
        check_eq("in_ro", rdat, in_base);

        // Async reset mid-operation
        check_eq("pre_rst_oe", {24'b0, pin_oe}, 32'h10);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_oe", {24'b0, pin_oe}, 32'h0);
        check_eq("async_out", {24'b0, pin_out}, 32'h0);
        check_eq("async_rdata", reg_rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        rd(ADDR_DIR, rdat);
        check_eq("post_rst_dir", rdat, 32'h0);
        rd(ADDR_IRQ_EN, rdat);
        check_eq("post_rst_en", rdat, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
